imm_ext_pipe: RTL and testbench
===============================

// Module: imm_ext_pipe
// PURPOSE
//  Registered, parametrised immediate extender between D and E stages. It takes an
//  IMM_W-bit immediate, a 3-bit mode and a tag (PC) under a valid/ready handshake.
//  It delivers the DATA_W-bit extended value through a 2-entry skid buffer, so
//  back-pressure from E never drops a value. A synchronous flush kills in-flight entries.
// PARAMETERS
//  IMM_W   16  immediate width
//  DATA_W  32  extended output width; DATA_W >= IMM_W+2
//  TAG_W   32  passthrough tag width (PC)
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       async active-low reset
//  flush      in   1       sync kill of all buffered entries
//  in_valid   in   1       input entry valid
//  in_ready   out  1       block can accept an entry this cycle
//  in_imm     in   IMM_W   raw immediate
//  in_mode    in   3       extension mode (see BEHAVIOUR)
//  in_tag     in   TAG_W   tag carried with entry
//  out_valid  out  1       output entry valid
//  out_ready  in   1       consumer accepts output this cycle
//  out_imm    out  DATA_W  extended immediate
//  out_tag    out  TAG_W   tag of output entry
//  out_err    out  1       entry had an illegal mode
// BEHAVIOUR
//  Modes (computed combinationally on the input side, then registered):
//   0 ZERO : {0, imm}            1 SIGN : {{imm[MSB]}, imm}
//   2 HIGH : {imm, 0}, low DATA_W-IMM_W bits zero
//   3 BR   : SIGN value << 2, bits shifted out above DATA_W discarded
//   4 ZSH2 : ZERO value << 2     5-7 : out_imm=0, out_err=1
//  Storage: main reg (drives out_*) + skid reg. States EMPTY, ONE, TWO.
//   in_ready  = (state!=TWO), registered, no comb path from out_ready.
//   out_valid = (state!=EMPTY).
//   acc = in_valid & in_ready; pop = out_valid & out_ready.
//  Transitions (absent flush):
//   EMPTY: acc -> ONE (main<=new)
//   ONE  : acc&pop -> ONE (main<=new); acc&!pop -> TWO (skid<=new);
//          !acc&pop -> EMPTY; else hold
//   TWO  : pop -> ONE (main<=skid); else hold (no acc possible)
//  Latency: entry accepted at edge N is visible on out_* after edge N, i.e. in the
//   cycle following acceptance. Order is strictly FIFO.
//  Flush: highest priority. On an edge with flush=1 -> EMPTY. A same-cycle acc
//   is dropped and a same-cycle pop still counts for the consumer. in_ready=1 next cycle.
//  out_* data bits hold the last value when out_valid=0. Consumer ignores them.
//  Reset (rst_n=0, async, mid-operation too): state EMPTY, out_valid=0,
//   in_ready=1, out_imm=0, out_tag=0, out_err=0, skid contents=0.
//  While out_valid=1 & !out_ready, out_imm/out_tag/out_err are stable.
// TESTING
//  1 SIGN imm=16'h8004, out_ready=1 -> next cycle out_imm=32'hFFFF8004, err=0
//  2 modes 0/2/3/4 on imm=16'hC001 -> 0000C001 / C0010000 / FFFF0004 / 00030004
//  3 out_ready=0, send 3 entries -> 2 accepted, in_ready=0 after 2nd; then
//    release -> both drain in order, tags match, in_ready=1
//  4 flush in state TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1,
//    the new entry is never output
//  5 mode=6 imm=16'hFFFF -> out_imm=0, out_err=1; rst_n low mid-stream ->
//    out_valid=0 immediately (async), all outputs 0
//  6 back-to-back stream, out_ready=1 every cycle -> 1 entry/cycle, no bubbles

Source files
------------

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender sitting between the D and E stages.
// An incoming immediate is widened according to its mode and then held in
// a two-entry skid buffer (main + skid registers). Because in_ready is
// registered, there is no combinational path from out_ready back to in_ready.
module imm_ext_pipe #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [2:0]        in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    localparam int PAD_W = DATA_W - IMM_W;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_in_ready;

    logic [DATA_W-1:0]   r_main_imm;
    logic [TAG_W-1:0]    r_main_tag;
    logic                r_main_err;
    logic [DATA_W-1:0]   r_skid_imm;
    logic [TAG_W-1:0]    r_skid_tag;
    logic                r_skid_err;

    logic [DATA_W-1:0]   w_zero;
    logic [DATA_W-1:0]   w_sign;
    logic [DATA_W-1:0]   w_ext_imm;
    logic                w_ext_err;
    logic                w_acc;
    logic                w_pop;
    logic                w_load_main_new;
    logic                w_load_main_skid;
    logic                w_load_skid_new;

    assign w_zero = {{PAD_W{1'b0}}, in_imm};
    assign w_sign = {{PAD_W{in_imm[IMM_W-1]}}, in_imm};

    // Extend the incoming immediate according to its mode; modes 5-7 are illegal.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_ext_imm = '0;
        w_ext_err = 1'b0;
        unique case (in_mode)
            3'd0:    w_ext_imm = w_zero;
            3'd1:    w_ext_imm = w_sign;
            3'd2:    w_ext_imm = {in_imm, {PAD_W{1'b0}}};
            3'd3:    w_ext_imm = w_sign << 2;
            3'd4:    w_ext_imm = w_zero << 2;
            default: w_ext_err = 1'b1;
        endcase
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != S_EMPTY);
    assign w_acc     = in_valid & r_in_ready;
    assign w_pop     = out_valid & out_ready;

    // Next-state and register-load selection; flush overrides everything.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_new  = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid_new  = 1'b0;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt     = S_ONE;
                        w_load_main_new = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_acc && w_pop) begin
                        w_load_main_new = 1'b1;
                    end else if (w_acc) begin
                        w_state_nxt     = S_TWO;
                        w_load_skid_new = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt     = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_pop) begin
                        w_state_nxt      = S_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // State register and registered in_ready (low only while both slots are full).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != S_TWO);
        end
    end

    // Main and skid data registers; contents hold whenever no load is selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the skid slot is cleared too, so outputs are all-zero out of reset and never X.
            r_main_imm <= '0;
            r_main_tag <= '0;
            r_main_err <= 1'b0;
            r_skid_imm <= '0;
            r_skid_tag <= '0;
            r_skid_err <= 1'b0;
        end else begin
            if (w_load_main_new) begin
                r_main_imm <= w_ext_imm;
                r_main_tag <= in_tag;
                r_main_err <= w_ext_err;
            end else if (w_load_main_skid) begin
                r_main_imm <= r_skid_imm;
                r_main_tag <= r_skid_tag;
                r_main_err <= r_skid_err;
            end
            if (w_load_skid_new) begin
                r_skid_imm <= w_ext_imm;
                r_skid_tag <= in_tag;
                r_skid_err <= w_ext_err;
            end
        end
    end

    assign out_imm = r_main_imm;
    assign out_tag = r_main_tag;
    assign out_err = r_main_err;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed scenarios followed by a
// randomized stream, all compared against a queue-based reference model.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_imm = '0;
    logic [2:0]  in_mode = '0;
    logic [31:0] in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_imm;
    logic [31:0] out_tag;
    logic        out_err;

    typedef struct {
        logic [31:0] imm;
        logic [31:0] tag;
        logic        err;
    } ent_t;

    ent_t q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    imm_ext_pipe #(.IMM_W(16), .DATA_W(32), .TAG_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference extension from the mode rules, using plain integer arithmetic.
    function automatic ent_t ref_ext(input logic [15:0] imm, input logic [2:0] mode,
                                     input logic [31:0] tag);
        ent_t   e;
        longint u;
        longint s;
        longint r;
        logic [63:0] rv;
        u = longint'(imm);
        s = (u >= 32768) ? u - 65536 : u;
        e.err = 1'b0;
        case (mode)
            3'd0:    r = u;
            3'd1:    r = s;
            3'd2:    r = u * 65536;
            3'd3:    r = s * 4;
            3'd4:    r = u * 4;
            default: begin r = 0; e.err = 1'b1; end
        endcase
        rv    = r;
        e.imm = rv[31:0];
        e.tag = tag;
        return e;
    endfunction

    // Compare visible DUT outputs against the model queue.
    task automatic compare();
        check("out_valid", out_valid, q.size() != 0);
        check("in_ready", in_ready, q.size() < 2);
        if (q.size() != 0) begin
            check("out_imm", out_imm, q[0].imm);
            check("out_tag", out_tag, q[0].tag);
            check("out_err", out_err, q[0].err);
        end
    endtask

    // One cycle: drive at negedge, advance model across the edge, compare at next negedge.
    task automatic step(input bit v, input logic [15:0] imm, input logic [2:0] mode,
                        input logic [31:0] tag, input bit rdy, input bit fl);
        bit acc;
        bit pop;
        in_valid  = v;
        in_imm    = imm;
        in_mode   = mode;
        in_tag    = tag;
        out_ready = rdy;
        flush     = fl;
        acc = v && (q.size() < 2);
        pop = rdy && (q.size() != 0);
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(ref_ext(imm, mode, tag));
        end
        @(negedge clk);
        compare();
    endtask

    task automatic check_zero_outputs(input string pfx);
        check({pfx, "_valid"}, out_valid, 1'b0);
        check({pfx, "_ready"}, in_ready, 1'b1);
        check({pfx, "_imm"}, out_imm, 32'h0);
        check({pfx, "_tag"}, out_tag, 32'h0);
        check({pfx, "_err"}, out_err, 1'b0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check_zero_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        compare();

        // 1: SIGN extension of a negative immediate
        step(1, 16'h8004, 3'd1, 32'h100, 1, 0);
        check("t1_imm", out_imm, 32'hFFFF8004);
        check("t1_err", out_err, 1'b0);

        // 2: modes 0/2/3/4 on 0xC001
        step(1, 16'hC001, 3'd0, 32'h200, 1, 0);
        check("t2_zero", out_imm, 32'h0000C001);
        step(1, 16'hC001, 3'd2, 32'h201, 1, 0);
        check("t2_high", out_imm, 32'hC0010000);
        step(1, 16'hC001, 3'd3, 32'h202, 1, 0);
        check("t2_br", out_imm, 32'hFFFF0004);
        step(1, 16'hC001, 3'd4, 32'h203, 1, 0);
        check("t2_zsh2", out_imm, 32'h00030004);
        step(0, 16'h0, 3'd0, 32'h0, 1, 0);
        check("t2_drained", out_valid, 1'b0);

        // 3: back-pressure fills both slots, third entry refused, then drains in order
        step(1, 16'h0011, 3'd0, 32'h301, 0, 0);
        check("t3_ready1", in_ready, 1'b1);
        step(1, 16'h0022, 3'd0, 32'h302, 0, 0);
        check("t3_ready2", in_ready, 1'b0);
        step(1, 16'h0033, 3'd0, 32'h303, 0, 0);
        check("t3_hold_tag", out_tag, 32'h301);
        step(0, 16'h0, 3'd0, 32'h0, 1, 0);
        check("t3_second_tag", out_tag, 32'h302);
        check("t3_ready_back", in_ready, 1'b1);
        step(0, 16'h0, 3'd0, 32'h0, 1, 0);
        check("t3_empty", out_valid, 1'b0);

        // 4: flush while full with a new entry offered
        step(1, 16'h0041, 3'd1, 32'h401, 0, 0);
        step(1, 16'h0042, 3'd1, 32'h402, 0, 0);
        step(1, 16'h0043, 3'd1, 32'h403, 0, 1);
        check("t4_valid", out_valid, 1'b0);
        check("t4_ready", in_ready, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step(0, 16'h0, 3'd0, 32'h0, 1, 0);
            check("t4_never_out", out_valid, 1'b0);
        end

        // 5: illegal mode, then asynchronous reset mid-stream
        step(1, 16'hFFFF, 3'd6, 32'h501, 1, 0);
        check("t5_imm", out_imm, 32'h0);
        check("t5_err", out_err, 1'b1);
        step(1, 16'h1234, 3'd1, 32'h502, 0, 0);
        step(1, 16'h5678, 3'd1, 32'h503, 0, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("t5_async");
        q.delete();
        @(negedge clk);
        check_zero_outputs("t5_held");
        rst_n = 1'b1;
        @(negedge clk);
        compare();

        // 6: back-to-back stream with the consumer always ready
        for (int i = 0; i < 20; i++) begin
            step(1, 16'($urandom), 3'($urandom_range(0, 4)), 32'(600 + i), 1, 0);
            check("t6_valid", out_valid, 1'b1);
            check("t6_tag", out_tag, 32'(600 + i));
        end

        // Randomized traffic with back-pressure and occasional flush
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, 16'($urandom), 3'($urandom_range(0, 7)),
                 $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
